// File: rtl/clock_gate_pkg.sv
// clock_gate_pkg: shared state encodings and default sizing for clock-gating controllers
package clock_gate_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;
  localparam int IDLE_W_DEF = 8;
  localparam int WAKE_CYCLES_DEF = 2;
endpackage

// File: rtl/EICG_wrapper.sv
// EICG_wrapper: latch-based glitch-free clock gate with test override
module EICG_wrapper (
  input  logic in,
  input  logic en,
  input  logic test_en,
  output logic out
);
  logic en_q;
  // enable is captured only while the clock is low, so out cannot glitch
  always_latch
    if (!in) en_q <= en | test_en;
  assign out = in & en_q;
endmodule

// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: idle-hysteresis sequencer deciding when a domain clock stops and restarts
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int IDLE_W = IDLE_W_DEF,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_gate_enable,
  input  logic [IDLE_W-1:0] cfg_idle_thresh,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              test_en,
  output logic              gclk,
  output logic              clk_en,
  output logic              gated,
  output logic              wake_ack
);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  state_t state, state_n;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n, thresh_q, thresh_n;
  logic [WW-1:0] wake_cnt, wake_cnt_n;
  logic clk_en_n, gated_n, wake_ack_n;
  logic idle, ack_req, wake_done;
  assign idle = cfg_gate_enable & ~busy & ~wake_req;
  assign ack_req = wake_req & ~wake_ack;
  assign wake_done = wake_cnt == WW'(WAKE_CYCLES - 1);
  // state, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_RUN;
      idle_cnt <= '0;
      thresh_q <= '0;
      wake_cnt <= '0;
      clk_en   <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
    end else begin
      state    <= state_n;
      idle_cnt <= idle_cnt_n;
      thresh_q <= thresh_n;
      wake_cnt <= wake_cnt_n;
      clk_en   <= clk_en_n;
      gated    <= gated_n;
      wake_ack <= wake_ack_n;
    end
  end
  // next-state: non-idle always wins over a threshold match; WAKE runs to completion
  always_comb begin
    state_n    = state;
    idle_cnt_n = idle_cnt;
    thresh_n   = thresh_q;
    wake_cnt_n = wake_cnt;
    clk_en_n   = clk_en;
    gated_n    = gated;
    wake_ack_n = 1'b0;
    case (state)
      ST_RUN: begin
        wake_ack_n = ack_req;
        if (idle) begin
          state_n    = ST_COUNT;
          idle_cnt_n = '0;
          thresh_n   = cfg_idle_thresh;
        end
      end
      ST_COUNT: begin
        wake_ack_n = ack_req;
        if (!idle) state_n = ST_RUN;
        else if (idle_cnt == thresh_q) begin
          state_n  = ST_GATED;
          clk_en_n = 1'b0;
          gated_n  = 1'b1;
        end else idle_cnt_n = idle_cnt + 1'b1;
      end
      ST_GATED:
        if (busy | wake_req | ~cfg_gate_enable) begin
          state_n    = ST_WAKE;
          clk_en_n   = 1'b1;
          gated_n    = 1'b0;
          wake_cnt_n = '0;
        end
      ST_WAKE: begin
        wake_cnt_n = wake_cnt + 1'b1;
        if (wake_done) begin
          state_n    = ST_RUN;
          wake_ack_n = wake_req;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end
  EICG_wrapper u_gate (
    .in(clock),
    .en(clk_en),
    .test_en(test_en),
    .out(gclk)
  );
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb_clock_gate_ctrl: directed and random checks of the gating sequencer against a run-length model
module tb_clock_gate_ctrl;
  localparam int IDLE_W = 8;
  localparam int WAKE_CYCLES = 2;
  logic clock = 1'b0, reset = 1'b1, cfg_gate_enable = 1'b1;
  logic [IDLE_W-1:0] cfg_idle_thresh = 8'd3;
  logic busy = 1'b0, wake_req = 1'b0, test_en = 1'b0;
  logic gclk, clk_en, gated, wake_ack;
  int n_cmp = 0, n_err = 0;
  int gcnt = 0, gbase = 0, gexp = 0;
  bit gclk_on = 0;
  bit m_en = 1, m_gated = 0, m_ack = 0;
  int run = 0, thr = 0, wake_left = 0;

  clock_gate_ctrl #(.IDLE_W(IDLE_W), .WAKE_CYCLES(WAKE_CYCLES)) dut (
    .clock(clock), .reset(reset), .cfg_gate_enable(cfg_gate_enable),
    .cfg_idle_thresh(cfg_idle_thresh), .busy(busy), .wake_req(wake_req),
    .test_en(test_en), .gclk(gclk), .clk_en(clk_en), .gated(gated), .wake_ack(wake_ack)
  );

  always #5 clock = ~clock;
  always @(posedge gclk) gcnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // model: gating happens after thresh+2 consecutive idle samples; waking takes WAKE_CYCLES edges
  task automatic tick();
    bit g, idle, ack_new;
    g = m_en | test_en;
    @(posedge clock);
    idle = cfg_gate_enable && !busy && !wake_req;
    if (reset) begin
      m_en = 1; m_gated = 0; m_ack = 0; run = 0; wake_left = 0;
    end else if (m_gated) begin
      m_ack = 0;
      if (busy || wake_req || !cfg_gate_enable) begin
        m_gated = 0; m_en = 1; wake_left = WAKE_CYCLES;
      end
    end else if (wake_left > 0) begin
      wake_left--;
      m_ack = (wake_left == 0) && wake_req;
      run = 0;
    end else begin
      ack_new = wake_req && !m_ack;
      if (idle) begin
        if (run == 0) thr = int'(cfg_idle_thresh);
        run++;
        if (run == thr + 2) begin
          m_en = 0; m_gated = 1; run = 0;
        end
      end else run = 0;
      m_ack = ack_new;
    end
    @(negedge clock);
    gexp += int'(g);
    chk("clk_en", int'(clk_en), int'(m_en));
    chk("gated", int'(gated), int'(m_gated));
    chk("wake_ack", int'(wake_ack), int'(m_ack));
    if (gclk_on) chk("gclk_edges", gcnt - gbase, gexp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    @(negedge clock);
    reset = 1'b1;
    ticks(3);
    chk("rst_clk_en", int'(clk_en), 1);
    chk("rst_gated", int'(gated), 0);
    chk("rst_ack", int'(wake_ack), 0);
    gbase = gcnt; gexp = 0; gclk_on = 1;
    reset = 1'b0; busy = 1'b0; cfg_idle_thresh = 8'd3;
    ticks(4);
    chk("pre_gate", int'(gated), 0);
    tick();
    chk("gate_at5", int'(gated), 1);
    ticks(3);
    wake_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_ack) wake_req = 1'b0;
    end
    wake_req = 1'b0; busy = 1'b1;
    tick();
    busy = 1'b0;
    ticks(3);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    ticks(4);
    chk("fresh_count", int'(gated), 0);
    tick();
    chk("fresh_gate", int'(gated), 1);
    busy = 1'b1;
    ticks(4);
    busy = 1'b0;
    ticks(6);
    test_en = 1'b1;
    ticks(4);
    test_en = 1'b0;
    wake_req = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_ack) wake_req = 1'b0;
    end
    wake_req = 1'b0;
    ticks(6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cfg_gate_enable = 1'b0;
    ticks(20);
    chk("no_gate_disabled", int'(gated), 0);
    cfg_gate_enable = 1'b1;
    ticks(2);
    cfg_gate_enable = 1'b0;
    tick();
    cfg_gate_enable = 1'b1; cfg_idle_thresh = 8'd0;
    tick();
    cfg_idle_thresh = 8'd9;
    tick();
    chk("thresh0_gate", int'(gated), 1);
    cfg_gate_enable = 1'b0;
    ticks(3);
    cfg_gate_enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      busy = ($urandom_range(0, 7) == 0);
      cfg_gate_enable = ($urandom_range(0, 15) != 0);
      test_en = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) cfg_idle_thresh = 8'($urandom_range(0, 6));
      if (m_ack) wake_req = 1'b0;
      else if (!wake_req) wake_req = ($urandom_range(0, 19) == 0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
- Idle-hysteresis sequencer for one clock-gated domain.
- Watches the domain's activity and waking requests, and decides when the domain's clock is stopped and restarted.
- Drives the enable of one integrated clock-gating cell (EICG_wrapper), which it instantiates.
- Runs on the free-running clock and sits beside each gated subsystem (e.g. the debug or peripheral cluster).

Parameters:
IDLE_W, 8, width of the idle-threshold configuration and the idle counter
WAKE_CYCLES, 2, cycles of running clock the domain receives before wake_ack is pulsed (>=1)

Ports:
clock  input  1  free-running clock; controller logic and gate-cell input
reset  input  1  synchronous, active-high reset
cfg_gate_enable  input  1  1 = automatic gating allowed; 0 = domain clock forced running
cfg_idle_thresh  input  IDLE_W  idle hysteresis value; latched on entry to COUNT
busy  input  1  domain activity; any 1 blocks or cancels gating
wake_req  input  1  level request for a running clock; requester holds it until wake_ack
test_en  input  1  scan/test override, routed to the gate cell test_en
gclk  output  1  gated domain clock (EICG_wrapper out)
clk_en  output  1  registered enable driving the gate cell en
gated  output  1  1 while in GATED
wake_ack  output  1  one-cycle registered acknowledge of wake_req

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- States: RUN, COUNT, GATED, WAKE. Encoding is 2 bits.
- Reset values: state=RUN, clk_en=1, gated=0, wake_ack=0, idle_cnt=0, wake_cnt=0, thresh_q=0.
- Idle sample: a cycle with cfg_gate_enable=1, busy=0 and wake_req=0.
- RUN:
  - On an idle sample: go to COUNT, idle_cnt<=0, thresh_q<=cfg_idle_thresh.
  - Otherwise stay in RUN.
- COUNT:
  - On a non-idle sample: go to RUN. Non-idle wins over a simultaneous cnt==thresh match.
  - On an idle sample with idle_cnt==thresh_q: go to GATED, clk_en<=0, gated<=1.
  - On an idle sample otherwise: idle_cnt<=idle_cnt+1.
  - Result: clk_en falls on the edge after thresh+2 consecutive idle samples. thresh=0 gives 2 samples.
  - The counter never wraps, because it stops at thresh_q.
- GATED:
  - clk_en=0.
  - Any of busy=1, wake_req=1 or cfg_gate_enable=0 moves to WAKE with clk_en<=1, gated<=0, wake_cnt<=0.
- WAKE:
  - wake_cnt increments each cycle.
  - When wake_cnt==WAKE_CYCLES-1: go to RUN. If wake_req=1 in that cycle, wake_ack<=1.
  - WAKE is not abortable. Inputs are ignored until it returns to RUN.
- wake_ack in RUN/COUNT: if wake_req=1 and wake_ack=0, then wake_ack<=1 next cycle, and COUNT also returns to RUN.
- wake_ack is always a single-cycle pulse. The requester drops wake_req in the ack cycle. A wake_req held for 2 or more cycles after an ack produces a new ack every other cycle (allowed, not an error).
- Gate cell timing:
  - clk_en feeds the gate cell en directly.
  - gclk stops or starts at the first clock high phase after the clk_en edge.
  - No gclk glitches; the gate cell latches en while clock is low.
- test_en=1 forces gclk running through the gate cell. The FSM, clk_en and gated are unaffected.
- cfg_gate_enable falling while in COUNT returns to RUN the next cycle.
- cfg_idle_thresh changes after COUNT entry are ignored until the next entry.
- reset asserted in any state, including GATED or WAKE, gives state RUN and clk_en=1 on that edge. A pending wake_ack is cleared.

Decomposition:
- Shared package/include clock_gate_pkg: state encodings (ST_RUN=0, ST_COUNT=1, ST_GATED=2, ST_WAKE=3) and default IDLE_W/WAKE_CYCLES constants, reused by future multi-domain gating controllers.
- One sub-module: EICG_wrapper instance (in=clock, en=clk_en, test_en=test_en, out=gclk).
- FSM, counters and ack logic stay flat in clock_gate_ctrl.

Test Plan:
- Reset then idle, thresh=3: busy=0 from cycle 0 -> COUNT at cycle 1, clk_en=0 and gated=1 after cycle 5 edge, gclk flat thereafter.
- thresh=3, busy pulses high on the 4th idle cycle -> return to RUN, clk_en stays 1. A fresh count of 5 idle samples is then required before gating.
- GATED, wake_req=1 held, WAKE_CYCLES=2 -> clk_en=1 next edge, gclk toggles, wake_ack pulses exactly once 2 cycles later, gated=0.
- GATED, busy=1 (no wake_req) -> WAKE then RUN after 2 cycles, wake_ack stays 0 throughout.
- test_en=1 while GATED -> gclk toggles every cycle, clk_en=0, gated=1 unchanged.
- reset asserted in WAKE cycle 0 and in GATED -> state RUN, clk_en=1, wake_ack=0 on the next edge. cfg_gate_enable=0 for 20 idle cycles -> never gates.
